// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic             overflow;
`endif

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      , input overflow
`endif
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      , output overflow
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus registered borrow.
// Optional signed overflow output: define SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh, b_sh, diff_q;
   logic             br, borrow_q;
   logic             in_ready_q, out_valid_q;
   logic             x, y, d, br_next, last;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic             a_msb, b_msb, overflow_q;
`endif

   // Full-subtractor cell on the current LSBs
   assign x       = a_sh[0];
   assign y       = b_sh[0];
   assign d       = x ^ y ^ br;
   assign br_next = (~x & y) | (~(x ^ y) & br);
   assign last    = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_next = RUN;
         RUN:     if (last)          state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         a_sh        <= '0;
         b_sh        <= '0;
         diff_q      <= '0;
         br          <= 1'b0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         a_msb       <= 1'b0;
         b_msb       <= 1'b0;
         overflow_q  <= 1'b0;
`endif
      end else begin
         in_ready_q  <= (state_next == IDLE);
         out_valid_q <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh <= bus.a;
                  b_sh <= bus.b;
                  br   <= 1'b0;
                  cnt  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                  a_msb <= bus.a[WIDTH-1];
                  b_msb <= bus.b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               diff_q <= {d, diff_q[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               br     <= br_next;
               cnt    <= cnt + CNT_W'(1);
               if (last) begin
                  borrow_q <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                  // d is the final diff MSB on the last step
                  overflow_q <= (a_msb != b_msb) && (d != a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   assign bus.overflow   = overflow_q;
`endif
endmodule
